// File: rtl/trivium_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trivium_pkg                                                                |
// | Shared widths, FSM encoding, tap positions and load helper for Trivium.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package trivium_pkg;

  localparam int STATE_W             = 288;
  localparam int KEY_W               = 80;
  localparam int IV_W                = 80;
  localparam int INIT_ROUNDS_DEFAULT = 1152;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Tap positions, zero-based: c_sN addresses cipher bit s(N).
  localparam int c_s66  = 65;
  localparam int c_s69  = 68;
  localparam int c_s91  = 90;
  localparam int c_s92  = 91;
  localparam int c_s93  = 92;
  localparam int c_s162 = 161;
  localparam int c_s171 = 170;
  localparam int c_s175 = 174;
  localparam int c_s176 = 175;
  localparam int c_s177 = 176;
  localparam int c_s243 = 242;
  localparam int c_s264 = 263;
  localparam int c_s286 = 285;
  localparam int c_s287 = 286;
  localparam int c_s288 = 287;

  localparam int c_IV_BASE   = 93;
  localparam int c_ONES_BASE = 285;

  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] s;
    s                       = '0;
    s[KEY_W-1:0]            = key;
    s[c_IV_BASE +: IV_W]    = iv;
    s[c_ONES_BASE +: 3]     = 3'b111;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trivium_step                                                               |
// | One combinational Trivium step: next 288-bit state plus one keystream bit.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trivium_step
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  output logic [STATE_W-1:0] o_state,
  output logic               o_z
);

  logic w_t1;
  logic w_t2;
  logic w_t3;
  logic w_f1;
  logic w_f2;
  logic w_f3;

  always_comb begin
    w_t1 = i_state[c_s66]  ^ i_state[c_s93];
    w_t2 = i_state[c_s162] ^ i_state[c_s177];
    w_t3 = i_state[c_s243] ^ i_state[c_s288];
    o_z  = w_t1 ^ w_t2 ^ w_t3;

    w_f1 = w_t1 ^ (i_state[c_s91]  & i_state[c_s92])  ^ i_state[c_s171];
    w_f2 = w_t2 ^ (i_state[c_s175] & i_state[c_s176]) ^ i_state[c_s264];
    w_f3 = w_t3 ^ (i_state[c_s286] & i_state[c_s287]) ^ i_state[c_s69];

    // Three registers shift toward higher indices; each head takes the feedback of another.
    o_state = {i_state[286:177], w_f2,
               i_state[175:93],  w_f1,
               i_state[91:0],    w_f3};
  end

endmodule
`default_nettype wire

// File: rtl/trivium_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trivium_stream                                                             |
// | Trivium keystream generator, W bits per cycle, load / warm-up / run FSM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trivium_stream
  import trivium_pkg::*;
#(
  parameter int W           = 1,
  parameter int INIT_ROUNDS = INIT_ROUNDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_i,
  input  logic [IV_W-1:0]  iv_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic [W-1:0]     ks_data_o,
  output logic             ks_valid_o,
  input  logic             ks_ready_i,
  output logic             busy_o
);

  localparam int c_INIT_CYCLES = INIT_ROUNDS / W;
  localparam int c_CNT_W       = $clog2(c_INIT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_INIT_CYCLES - 1);

  state_t             r_fsm;
  state_t             w_fsm_next;
  logic [STATE_W-1:0] r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_load;
  logic               w_advance;
  logic [STATE_W-1:0] w_chain [W+1];
  logic [W-1:0]       w_z;

  assign w_chain[0] = r_state;

  // Bit j of the output word comes from the j-th step of the chain.
  for (genvar g = 0; g < W; g++) begin : g_step
    trivium_step u_step (
      .i_state (w_chain[g]),
      .o_state (w_chain[g+1]),
      .o_z     (w_z[g])
    );
  end

  assign ks_data_o = w_z;

  always_comb begin
    w_fsm_next   = r_fsm;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    load_ready_o = 1'b0;
    ks_valid_o   = 1'b0;
    busy_o       = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          w_load     = 1'b1;
          w_fsm_next = ST_INIT;
        end
      end
      ST_INIT: begin
        busy_o    = 1'b1;
        w_advance = 1'b1;
        if (r_cnt == c_CNT_LAST) begin
          w_fsm_next = ST_RUN;
        end
      end
      ST_RUN: begin
        load_ready_o = 1'b1;
        ks_valid_o   = 1'b1;
        // A load outranks the advance; a coincident handshake still delivers the word.
        if (load_valid_i) begin
          w_load     = 1'b1;
          w_fsm_next = ST_INIT;
        end else if (ks_ready_i) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_fsm_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (w_load) begin
      r_state <= load_state(key_i, iv_i);
    end else if (w_advance) begin
      r_state <= w_chain[W];
    end
  end

  // Counts warm-up cycles; the last increment lands on c_INIT_CYCLES, which fits the width.
  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_cnt <= '0;
    end else if (r_fsm == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trivium_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trivium_stream                                                          |
// | Self-checking bench: four widths against a bit-level Trivium model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_trivium_stream;

  localparam int NI    = 4;
  localparam int NBITS = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NI];
  logic [79:0] key        [NI];
  logic [79:0] iv         [NI];
  logic        load_valid [NI];
  logic        load_ready [NI];
  logic        ks_valid   [NI];
  logic        ks_ready   [NI];
  logic        busy       [NI];
  logic [63:0] ks_data    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GW = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
    logic [GW-1:0] data;
    trivium_stream #(.W(GW), .INIT_ROUNDS(1152)) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .key_i        (key[g]),
      .iv_i         (iv[g]),
      .load_valid_i (load_valid[g]),
      .load_ready_o (load_ready[g]),
      .ks_data_o    (data),
      .ks_valid_o   (ks_valid[g]),
      .ks_ready_i   (ks_ready[g]),
      .busy_o       (busy[g])
    );
    assign ks_data[g] = 64'(data);
  end

  int nvec = 0;
  int nerr = 0;
  bit exp_q[$];
  int pos;

  typedef struct {
    int          inst;
    logic [79:0] k;
    logic [79:0] v;
    int          exp_lat;
    int          nwords;
    int          stall_pct;
  } vec_t;
  vec_t tbl[5];

  function automatic int w_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 8 : (i == 2) ? 16 : 64;
  endfunction

  function automatic logic [79:0] rand80();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: eSTREAM Trivium with 1-based state s[1..288], 1152 warm-up steps.
  task automatic model_gen(input logic [79:0] k, input logic [79:0] v);
    bit s[1:288];
    bit t1, t2, t3, z;
    for (int n = 1; n <= 288; n++) s[n] = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      s[n]      = k[n-1];
      s[93 + n] = v[n-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    exp_q.delete();
    pos = 0;
    for (int step = 0; step < 1152 + NBITS; step++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      if (step >= 1152) exp_q.push_back(z);
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int n = 288; n >= 179; n--) s[n] = s[n-1];
      s[178] = t2;
      for (int n = 177; n >= 95; n--) s[n] = s[n-1];
      s[94] = t1;
      for (int n = 93; n >= 2; n--) s[n] = s[n-1];
      s[1] = t3;
    end
  endtask

  task automatic expect_word(input int i, output logic [63:0] e);
    e = '0;
    for (int j = 0; j < w_of(i); j++) e[j] = exp_q[pos + j];
  endtask

  task automatic do_load(input int i, input logic [79:0] k, input logic [79:0] v);
    key[i]        = k;
    iv[i]         = v;
    load_valid[i] = 1'b1;
    chk("load_ready_before_load", 64'(load_ready[i]), 64'd1);
    tick();
    load_valid[i] = 1'b0;
  endtask

  // Called at the negedge that follows the load edge plus 'start' further edges.
  task automatic wait_valid(input int i, input int exp_lat, input int start);
    int cnt;
    cnt = start;
    chk("busy_during_init", 64'(busy[i]), 64'd1);
    while (!ks_valid[i] && cnt <= exp_lat + 20) begin
      tick();
      cnt++;
    end
    chk("first_valid_latency", 64'(cnt), 64'(exp_lat));
    chk("busy_in_run", 64'(busy[i]), 64'd0);
  endtask

  task automatic read_words(input int i, input int nwords, input int stall_pct);
    int got;
    int cycles;
    logic [63:0] e;
    got = 0;
    cycles = 0;
    while (got < nwords && cycles < nwords * 50 + 100) begin
      ks_ready[i] = ($urandom_range(99) >= stall_pct);
      if (ks_valid[i] && ks_ready[i]) begin
        expect_word(i, e);
        chk("ks_word", ks_data[i], e);
        pos += w_of(i);
        got++;
      end
      tick();
      cycles++;
    end
    ks_ready[i] = 1'b0;
    if (got < nwords) chk("read_timeout", 64'(got), 64'(nwords));
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_load_ready"}, 64'(load_ready[i]), 64'd1);
    chk({tag, "_ks_valid"},   64'(ks_valid[i]),   64'd0);
    chk({tag, "_busy"},       64'(busy[i]),       64'd0);
    chk({tag, "_ks_data"},    ks_data[i],         64'd0);
  endtask

  initial begin
    logic [63:0] e;
    logic [79:0] ka, va;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; key[i] = '0; iv[i] = '0;
      load_valid[i] = 1'b0; ks_ready[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) chk_idle(i, "reset");
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    tick();

    tbl[0] = '{0, 80'd0,    80'd0,    1152, 256, 0};
    tbl[1] = '{3, 80'd0,    80'd0,    18,   4,   0};
    tbl[2] = '{1, rand80(), rand80(), 144,  40,  30};
    tbl[3] = '{2, rand80(), rand80(), 72,   20,  50};
    tbl[4] = '{3, rand80(), rand80(), 18,   8,   40};
    for (int t = 0; t < 5; t++) begin
      model_gen(tbl[t].k, tbl[t].v);
      do_load(tbl[t].inst, tbl[t].k, tbl[t].v);
      wait_valid(tbl[t].inst, tbl[t].exp_lat, 0);
      read_words(tbl[t].inst, tbl[t].nwords, tbl[t].stall_pct);
    end

    // W=8: five stalled cycles keep the word stable, then the stream resumes gap-free.
    ka = rand80(); va = rand80();
    model_gen(ka, va);
    do_load(1, ka, va);
    wait_valid(1, 144, 0);
    read_words(1, 3, 0);
    for (int c = 0; c < 5; c++) begin
      expect_word(1, e);
      chk("stall_word", ks_data[1], e);
      chk("stall_valid", 64'(ks_valid[1]), 64'd1);
      tick();
    end
    read_words(1, 10, 0);

    // W=1: a load request 500 cycles into warm-up is ignored.
    ka = rand80(); va = rand80();
    model_gen(ka, va);
    do_load(0, ka, va);
    repeat (500) tick();
    key[0] = rand80(); iv[0] = rand80();
    load_valid[0] = 1'b1;
    chk("init_load_ready", 64'(load_ready[0]), 64'd0);
    tick();
    load_valid[0] = 1'b0;
    wait_valid(0, 1152, 501);
    read_words(0, 64, 20);

    // W=16: reload in RUN with a coincident handshake.
    ka = rand80(); va = rand80();
    model_gen(ka, va);
    do_load(2, ka, va);
    wait_valid(2, 72, 0);
    read_words(2, 5, 0);
    expect_word(2, e);
    chk("reload_delivered_word", ks_data[2], e);
    chk("reload_valid", 64'(ks_valid[2]), 64'd1);
    ka = rand80(); va = rand80();
    key[2] = ka; iv[2] = va;
    load_valid[2] = 1'b1; ks_ready[2] = 1'b1;
    tick();
    load_valid[2] = 1'b0; ks_ready[2] = 1'b0;
    chk("reload_valid_falls", 64'(ks_valid[2]), 64'd0);
    model_gen(ka, va);
    wait_valid(2, 72, 0);
    read_words(2, 20, 30);

    // Reset mid-INIT with a competing load.
    do_load(3, rand80(), rand80());
    repeat (5) tick();
    chk("mid_init_busy", 64'(busy[3]), 64'd1);
    rst[3] = 1'b1; load_valid[3] = 1'b1;
    tick();
    rst[3] = 1'b0; load_valid[3] = 1'b0;
    chk_idle(3, "rst_mid_init");
    tick();
    chk_idle(3, "after_rst_mid_init");

    // Reset mid-RUN with competing load and handshake, then a fresh run.
    ka = rand80(); va = rand80();
    model_gen(ka, va);
    do_load(1, ka, va);
    wait_valid(1, 144, 0);
    read_words(1, 3, 0);
    rst[1] = 1'b1; load_valid[1] = 1'b1; ks_ready[1] = 1'b1;
    tick();
    rst[1] = 1'b0; load_valid[1] = 1'b0; ks_ready[1] = 1'b0;
    chk_idle(1, "rst_mid_run");
    model_gen(ka, va);
    do_load(1, ka, va);
    wait_valid(1, 144, 0);
    read_words(1, 4, 25);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
